// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//
// CPU-side initiator for a word-organised data memory. Accepts one load or
// store at a time from the core's MEM stage. Performs byte/halfword lane
// extraction with sign/zero extension for loads, and read-modify-write for
// byte/halfword stores. Misaligned accesses, illegal size codes and accesses
// beyond the end of memory complete immediately with a fault and no memory
// strobe.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req_valid    core presents a request
//   req_ready    request can be accepted (IDLE only)
//   req_write    1 = store, 0 = load
//   req_funct3   size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr     byte address
//   req_wdata    store data (low byte/half used for SB/SH)
//   resp_valid   one-cycle completion pulse
//   resp_rdata   extended load result, held until the next load response
//   resp_fault   fault flag, meaningful with resp_valid
//   mem_addr     word-aligned address to the data memory
//   mem_din      write word to the data memory (0 when not writing)
//   mem_read     read strobe (memory reads combinationally)
//   mem_write    write strobe (memory writes on the next rising edge)
//   mem_dout     read word from the data memory
// ---------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int unsigned MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  // One bit wider than the address so MEM_DEPTH*4 = 2^32 cannot overflow.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) * 33'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_STORE,
    S_RESP
  } state_t;

  state_t      state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_din_q;
  logic        mem_read_q;
  logic        mem_write_q;

  logic        accept_d;
  logic        f3_legal_d;
  logic        misalign_d;
  logic        range_d;
  logic        fault_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_data_d;
  logic [31:0] merged_d;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

  assign accept_d = req_valid && req_ready_q;

  // Fault classification on the live request inputs, used only at accept.
  assign f3_legal_d = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                                : (req_funct3 inside {3'b000, 3'b001, 3'b010,
                                                      3'b100, 3'b101});
  // funct3[1:0] encodes size for both loads and stores: 00 byte, 01 half, 10 word.
  assign misalign_d = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign range_d    = ({1'b0, req_addr} >= ADDR_LIMIT);
  assign fault_d    = !f3_legal_d || misalign_d || range_d;

  // Little-endian lane selection and extension of the word being read.
  always_comb begin
    byte_d = 8'h00;
    unique case (lane_q)
      2'd0: byte_d = mem_dout[7:0];
      2'd1: byte_d = mem_dout[15:8];
      2'd2: byte_d = mem_dout[23:16];
      2'd3: byte_d = mem_dout[31:24];
      default: byte_d = 8'h00;
    endcase
    half_d = lane_q[1] ? mem_dout[31:16] : mem_dout[15:0];

    load_data_d = mem_dout;
    unique case (funct3_q)
      3'b000:  load_data_d = {{24{byte_d[7]}}, byte_d};
      3'b001:  load_data_d = {{16{half_d[15]}}, half_d};
      3'b100:  load_data_d = {24'h000000, byte_d};
      3'b101:  load_data_d = {16'h0000, half_d};
      default: load_data_d = mem_dout;
    endcase
  end

  // Sub-word store merge: replace the addressed lane, keep the other bytes.
  always_comb begin
    merged_d = mem_dout;
    if (funct3_q[0] == 1'b0) begin
      unique case (lane_q)
        2'd0: merged_d[7:0]   = wdata_q[7:0];
        2'd1: merged_d[15:8]  = wdata_q[7:0];
        2'd2: merged_d[23:16] = wdata_q[7:0];
        2'd3: merged_d[31:24] = wdata_q[7:0];
        default: merged_d = mem_dout;
      endcase
    end else if (lane_q[1]) begin
      merged_d[31:16] = wdata_q[15:0];
    end else begin
      merged_d[15:0] = wdata_q[15:0];
    end
  end

  // Single-process FSM; every output is registered. mem_din_q doubles as the
  // merge register for SB/SH, so the merged word is driven straight out of it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_din_q    <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      // Pulsed outputs default low each cycle.
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_din_q    <= 32'h0;

      unique case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            funct3_q    <= req_funct3;
            lane_q      <= req_addr[1:0];
            wdata_q     <= req_wdata;
            mem_addr_q  <= {req_addr[31:2], 2'b00};
            req_ready_q <= 1'b0;
            if (fault_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
            end else if (!req_write) begin
              state_q    <= S_LOAD;
              mem_read_q <= 1'b1;
            end else if (req_funct3 == 3'b010) begin
              state_q     <= S_STORE;
              mem_write_q <= 1'b1;
              mem_din_q   <= req_wdata;
            end else begin
              state_q    <= S_RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          resp_rdata_q <= load_data_d;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end

        S_RMW_RD: begin
          mem_din_q   <= merged_d;
          mem_write_q <= 1'b1;
          state_q     <= S_STORE;
        end

        S_STORE: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end

        S_RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
//
// Scoreboard bench: the driver pushes the expected response of each request
// into a queue; a monitor pops and compares whenever resp_valid is seen and
// also watches the memory strobe rules every cycle.
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;

  localparam int MEM_DEPTH = 16384;
  localparam int AW        = 14;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  dmem_access_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read, write on rising edge.
  logic [31:0] mem [0:MEM_DEPTH-1];
  logic          pl_en;
  logic [AW-1:0] pl_idx;
  logic [31:0]   pl_data;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[AW+1:2]] <= mem_din;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end
  assign mem_dout = mem[mem_addr[AW+1:2]];

  typedef struct {
    string       name;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] waddr;
    int          lat;
    int          accept;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] last_rdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
      if (!mem_write) chk("din_zero_when_idle", mem_din, 32'h0);
      if ((mem_read || mem_write) && sb.size() > 0) chk({sb[0].name, "_mem_addr"}, mem_addr, sb[0].waddr);
      if (resp_valid) begin
        chk("no_ready_in_resp", {31'b0, req_ready}, 32'h0);
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_fault"}, {31'b0, resp_fault}, {31'b0, e.fault});
          chk({e.name, "_rdata"}, resp_rdata, e.rdata);
          chk({e.name, "_latency"}, 32'(cyc + 1 - e.accept), 32'(e.lat));
          chk({e.name, "_reads"}, 32'(rd_cnt), 32'(e.nrd));
          chk({e.name, "_writes"}, 32'(wr_cnt), 32'(e.nwr));
          $display("txn %-10s fault=%0d rdata=0x%08h lat=%0d rd=%0d wr=%0d",
                   e.name, resp_fault, resp_rdata, cyc + 1 - e.accept, rd_cnt, wr_cnt);
          resp_cnt++;
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Build the expected response for a request about to be accepted at the
  // next rising edge (called at a falling edge).
  task automatic push_exp(input string name, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic fault,
                          input logic [31:0] rd_exp);
    exp_t e;
    e.name   = name;
    e.fault  = fault;
    e.waddr  = {addr[31:2], 2'b00};
    e.accept = cyc + 1;
    if (fault) begin
      e.lat = 1; e.nrd = 0; e.nwr = 0; e.rdata = last_rdata;
    end else if (!wr) begin
      e.lat = 2; e.nrd = 1; e.nwr = 0; e.rdata = rd_exp;
      last_rdata = rd_exp;
    end else if (f3 == 3'b010) begin
      e.lat = 2; e.nrd = 0; e.nwr = 1; e.rdata = last_rdata;
    end else begin
      e.lat = 3; e.nrd = 1; e.nwr = 1; e.rdata = last_rdata;
    end
    sb.push_back(e);
  endtask

  // Leaves the caller at a falling edge with req_ready=1, or reports a timeout.
  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL resp_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one request; inputs are scrambled after accept to prove they are latched.
  task automatic issue(input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic fault, input logic [31:0] rd_exp);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      push_exp(name, wr, f3, addr, fault, rd_exp);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_write  = ~wr;
      req_funct3 = 3'b111;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h5A5A_5A5A;
    end
  endtask

  task automatic txn(input string name, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic fault, input logic [31:0] rd_exp);
    issue(name, wr, f3, addr, wd, fault, rd_exp);
    wait_drain();
  endtask

  initial begin : driver
    bit ok;
    int acc;
    int resp0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    pl_en      = 1'b0;
    pl_idx     = '0;
    pl_data    = 32'h0;

    repeat (2) @(negedge clk);
    pl_en   = 1'b1;
    pl_idx  = AW'(1);
    pl_data = 32'h8899_AABB;
    @(negedge clk);
    pl_en = 1'b0;

    // Reset state
    chk("rst_req_ready",  {31'b0, req_ready},  32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_fault", {31'b0, resp_fault}, 32'h0);
    chk("rst_mem_read",   {31'b0, mem_read},   32'h0);
    chk("rst_mem_write",  {31'b0, mem_write},  32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr",   mem_addr,   32'h0);
    chk("rst_mem_din",    mem_din,    32'h0);
    #2 reset = 1'b1;

    // Loads from mem[1] = 0x8899AABB
    txn("LB@5",   1'b0, 3'b000, 32'h5, 32'h0, 1'b0, 32'hFFFF_FFAA);
    txn("LBU@5",  1'b0, 3'b100, 32'h5, 32'h0, 1'b0, 32'h0000_00AA);
    txn("LHU@6",  1'b0, 3'b101, 32'h6, 32'h0, 1'b0, 32'h0000_8899);
    // Read-modify-write stores
    txn("SB@4",   1'b1, 3'b000, 32'h4, 32'hFFFF_FF11, 1'b0, 32'h0);
    txn("SH@6",   1'b1, 3'b001, 32'h6, 32'hABCD_2233, 1'b0, 32'h0);
    txn("LW@4",   1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h2233_AA11);
    txn("LH@6",   1'b0, 3'b001, 32'h6, 32'h0, 1'b0, 32'h0000_2233);
    txn("LB@4",   1'b0, 3'b000, 32'h4, 32'h0, 1'b0, 32'h0000_0011);
    // Full-word store
    txn("SW@10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    txn("LW@10",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    txn("LH@12",  1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_DEAD);
    txn("LB@13",  1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFDE);
    txn("SB@11",  1'b1, 3'b000, 32'h11, 32'h0000_0080, 1'b0, 32'h0);
    txn("LW@10b", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_80EF);
    txn("LB@11",  1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFF_FF80);
    // Faults: rdata must hold 0xFFFFFF80
    txn("F_LW@2",   1'b0, 3'b010, 32'h2,     32'h0, 1'b1, 32'h0);
    txn("F_SH@3",   1'b1, 3'b001, 32'h3,     32'h1234, 1'b1, 32'h0);
    txn("F_f3_011", 1'b0, 3'b011, 32'h0,     32'h0, 1'b1, 32'h0);
    txn("F_S_f3_4", 1'b1, 3'b100, 32'h0,     32'h0, 1'b1, 32'h0);
    txn("F_LW@lim", 1'b0, 3'b010, 32'h10000, 32'h0, 1'b1, 32'h0);

    // Reset during the STORE cycle of an SB
    issue("SB_rst", 1'b1, 3'b000, 32'h4, 32'h0000_0077, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_store_write_before", {31'b0, mem_write}, 32'h1);
    reset = 1'b0;
    #1;
    sb.delete();
    last_rdata = 32'h0;
    chk("rst_store_write_after", {31'b0, mem_write}, 32'h0);
    chk("rst_store_ready",       {31'b0, req_ready}, 32'h1);
    chk("rst_store_resp_valid",  {31'b0, resp_valid}, 32'h0);
    chk("rst_store_din",         mem_din, 32'h0);
    chk("rst_store_rdata",       resp_rdata, 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    txn("LW@4_post", 1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h2233_AA11);

    // req_valid held for 10 cycles: accepts only in IDLE (every third cycle)
    wait_ready(ok);
    acc   = 0;
    resp0 = resp_cnt;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) begin
        push_exp("LW_hold", 1'b0, 3'b010, 32'h10, 1'b0, 32'hDEAD_80EF);
        acc++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_drain();
    chk("hold_accepts",   32'(acc), 32'd4);
    chk("hold_responses", 32'(resp_cnt - resp0), 32'd4);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- CPU-side initiator for the word-organised data memory: accepts one load/store request at a time from the core and issues the memory-port accesses.
- Memory port: `mem_addr`, `mem_din`, `mem_read`, `mem_write`, `mem_dout`.
- The data memory only reads and writes full 32-bit words. This block therefore does byte-lane extraction and sign/zero extension for loads, and read-modify-write for byte/halfword stores.
- Sits between the core's MEM stage and the data memory. It also flags misaligned and out-of-range accesses.

Parameters:
- `MEM_DEPTH`, 16384, data memory size in 32-bit words. Byte addresses at or above `MEM_DEPTH*4` fault.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  block can accept a request (IDLE only).
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  size/sign code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte or half is used for SB/SH.
- `resp_valid`  out  1  one-cycle pulse: request complete.
- `resp_rdata`  out  32  load result, extended to 32 bits. Holds its value until the next load response.
- `resp_fault`  out  1  valid with `resp_valid`: misaligned, illegal funct3, or out-of-range.
- `mem_addr`  out  32  word-aligned byte address `{req_addr[31:2], 2'b00}`.
- `mem_din`  out  32  write word to the data memory.
- `mem_read`  out  1  read strobe; the data memory reads asynchronously.
- `mem_write`  out  1  write strobe; the data memory writes on the next rising edge.
- `mem_dout`  in  32  read word from the data memory, combinational.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - State is IDLE.
  - `req_ready`=1.
  - `resp_valid`, `resp_fault`, `mem_read`, `mem_write` = 0.
  - `resp_rdata`, `mem_addr`, `mem_din` = 0.
  - Any in-flight request is dropped, and `mem_write` deasserts immediately.
- Handshake:
  - A request is accepted on a rising edge with `req_valid`=1 and `req_ready`=1.
  - Address, data, funct3 and write flag are latched at that edge. Request inputs are don't-care afterwards.
- Faults are detected at accept. The request goes IDLE→RESP with `resp_fault`=1 and no memory strobe. A fault is raised for:
  - illegal funct3;
  - LH/LHU/SH with `addr[0]`≠0;
  - LW/SW with `addr[1:0]`≠0;
  - addr ≥ `MEM_DEPTH*4`.
- FSM states: IDLE, LOAD, RMW_RD, STORE, RESP.
  - IDLE: on accept, go to RESP if faulting, else LOAD (load), STORE (SW) or RMW_RD (SB/SH).
  - LOAD: `mem_read`=1 for one cycle; capture the extended lane into `resp_rdata` at the edge; go to RESP.
  - RMW_RD: `mem_read`=1 for one cycle; capture `mem_dout` into the merge register; go to STORE.
  - STORE: `mem_write`=1 for exactly one cycle. `mem_din` is the merged word for SB/SH, or `req_wdata` for SW. Go to RESP.
  - RESP: `resp_valid`=1 for one cycle; return to IDLE. `req_ready`=0 here, so there are no back-to-back accepts.
- Latency, counted from the accept edge to the `resp_valid` cycle:
  - load 2 cycles;
  - SW 2 cycles;
  - SB/SH 3 cycles;
  - fault 1 cycle.
- Byte lanes are little-endian.
  - Byte lane k (k = `addr[1:0]`) is `word[8k+7:8k]`.
  - Half lane h (h = `addr[1]`) is `word[16h+15:16h]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Merge: the selected lane(s) are replaced with `req_wdata[7:0]` or `[15:0]`; all other bytes are preserved from the read word.
- Strobe rules:
  - `mem_read` and `mem_write` are never both 1.
  - `mem_addr` is stable through all memory states of a request.
  - `mem_din`=0 whenever `mem_write`=0.
- On fault, `resp_rdata` keeps its previous value.

Test Plan:
- Preload `mem[1]`=0x8899AABB. LB @0x5 → `resp_rdata`=0xFFFFFFAA. LBU @0x5 → 0x000000AA. LHU @0x6 → 0x00008899. Each with `resp_valid` exactly 2 cycles after accept.
- SB 0x11 @0x4, then SH 0x2233 @0x6, on `mem[1]`=0x8899AABB → each shows one `mem_read` cycle then one `mem_write` cycle. Then LW @0x4 → 0x2233AA11.
- SW 0xDEADBEEF @0x10, then LW @0x10 → 0xDEADBEEF. The SW shows no `mem_read` cycle and a 2-cycle latency.
- Faults: LW @0x2, SH @0x3, funct3=011, LW @0x10000 (`MEM_DEPTH`=16384) → `resp_fault`=1 one cycle after accept, `mem_read`/`mem_write` never asserted, `resp_rdata` unchanged.
- Assert `reset`=0 mid-request during STORE of an SB → `mem_write` drops immediately, state is IDLE, `req_ready`=1. A following LW returns the pre-store word.
- `req_valid` held high for 10 cycles → accepts occur only in IDLE cycles, exactly one `resp_valid` pulse per accept, and no accept during RESP.
